// File: rtl/param_data_fifo_if.sv
// param_data_fifo_if: producer/consumer handshake bundle for param_data_fifo.
//   Write side : iData, iValid -> FIFO ; oReady <- FIFO
//   Read side  : oData, oValid <- FIFO ; iReady -> FIFO
//   Status     : oCount, oAlmostFull, oOverflow <- FIFO
// slave modport is the FIFO side; master modport is the producer/consumer side.
interface param_data_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] iData;
  logic             iValid;
  logic             oReady;
  logic [WIDTH-1:0] oData;
  logic             oValid;
  logic             iReady;
  logic [AW:0]      oCount;
  logic             oAlmostFull;
  logic             oOverflow;

  modport slave (
    input  iData, iValid, iReady,
    output oReady, oData, oValid, oCount, oAlmostFull, oOverflow
  );

  modport master (
    output iData, iValid, iReady,
    input  oReady, oData, oValid, oCount, oAlmostFull, oOverflow
  );
endinterface

// File: rtl/param_data_fifo.sv
// param_data_fifo: DEPTH-entry first-word-fall-through FIFO of WIDTH-bit words
// with valid/ready handshakes on both sides.
// Ports:
//   iClk   - clock, all state updates on the rising edge
//   iRst_n - asynchronous active-low reset
//   bus    - param_data_fifo_if.slave: write handshake (iData/iValid/oReady),
//            read handshake (oData/oValid/iReady), occupancy oCount,
//            oAlmostFull (oCount >= AFULL_TH), sticky oOverflow.
module param_data_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int AFULL_TH = DEPTH - 1
) (
  input  logic               iClk,
  input  logic               iRst_n,
  param_data_fifo_if.slave   bus
);
  localparam int          AW        = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_CNT = AFULL_TH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wPtr, rPtr;
  logic [AW:0]      count;
  logic             overflow;
  logic             push, pop;

  // Handshake qualifiers come from the registered count only, so there is
  // no combinational path from iValid to oReady or from iReady to oValid.
  assign push = bus.iValid & bus.oReady;
  assign pop  = bus.oValid & bus.iReady;

  // Storage is cleared on reset so the head word reads as 0 while in reset.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wPtr] <= bus.iData;
    end
  end

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wPtr     <= '0;
      rPtr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wPtr <= wPtr + 1'b1;
      if (pop)  rPtr <= rPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Any write attempt against a full FIFO latches until reset.
      if (bus.iValid && (count == FULL_CNT)) overflow <= 1'b1;
    end
  end

  assign bus.oData       = mem[rPtr];
  assign bus.oValid      = (count != '0);
  assign bus.oReady      = (count != FULL_CNT);
  assign bus.oCount      = count;
  assign bus.oAlmostFull = (count >= AFULL_CNT);
  assign bus.oOverflow   = overflow;
endmodule
